// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave time-entry keypad encoder.
// Imported by the interface, the encoder top and its code converter.
package microwave_pkg;

  localparam int BCD_W = 4;
  localparam int NUM_KEYS = 10;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [NUM_KEYS-1:0] keys_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } te_state_e;

  // A digit can move into the tens-of-seconds slot only if it is 0..5.
  function automatic logic tens_ok(input bcd_t d);
    return d <= BCD_W'(5);
  endfunction

endpackage

// File: rtl/time_entry_encoder_if.sv
// Keypad-side inputs and BCD time outputs of the time-entry encoder.
// master drives the keypad/controls, slave is the encoder.
interface time_entry_encoder_if;
  import microwave_pkg::*;

  keys_t keypad;
  logic  enable;
  logic  clear;
  bcd_t  sec_ones;
  bcd_t  sec_tens;
  bcd_t  min;
  logic  key_valid;
  bcd_t  key_code;
  logic  key_error;

  modport master (
    output keypad, enable, clear,
    input  sec_ones, sec_tens, min,
    input  key_valid, key_code, key_error
  );

  modport slave (
    input  keypad, enable, clear,
    output sec_ones, sec_tens, min,
    output key_valid, key_code, key_error
  );

endinterface

// File: rtl/onehot_to_bcd.sv
// Keypad pattern to BCD digit converter.
// onehot is high only when exactly one key bit is set.
module onehot_to_bcd
  import microwave_pkg::*;
(
  input  keys_t pattern,
  output bcd_t  code,
  output logic  onehot
);

  logic [3:0] ones_cnt;

  // Encode the highest set key and count how many keys are down.
  always_comb begin
    code = '0;
    ones_cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pattern[i]) begin
        code = BCD_W'(i);
        ones_cnt = ones_cnt + 4'd1;
      end
    end
    onehot = (ones_cnt == 4'd1);
  end

endmodule

// File: rtl/time_entry_encoder.sv
// Debounced keypad entry that shifts digits into an M:SS BCD time.
// Each debounced press is evaluated once; repeats need a debounced release.
module time_entry_encoder
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                clk,
  input logic                rst_n,
  time_entry_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  te_state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  keys_t pat_q, pat_d;
  bcd_t ones_q, ones_d;
  bcd_t tens_q, tens_d;
  bcd_t min_q, min_d;
  bcd_t code_q, code_d;
  logic valid_q, valid_d;
  logic error_q, error_d;

  bcd_t pat_code;
  logic pat_onehot;
  logic [CNT_W-1:0] count_inc;

  onehot_to_bcd u_conv (
    .pattern (pat_q),
    .code    (pat_code),
    .onehot  (pat_onehot)
  );

  assign count_inc = count_q + CNT_ONE;

  // Debounce FSM, press evaluation, digit shift and clear/enable overrides.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pat_d   = pat_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    min_d   = min_q;
    code_d  = code_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.keypad != '0) begin
          pat_d   = bus.keypad;
          count_d = CNT_ONE;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (bus.keypad == pat_q) begin
          count_d = count_inc;
          if (count_inc == CNT_MAX) begin
            state_d = HELD;
            if (pat_onehot && tens_ok(ones_q)) begin
              min_d   = tens_q;
              tens_d  = ones_q;
              ones_d  = pat_code;
              code_d  = pat_code;
              valid_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end else if (bus.keypad != '0) begin
          pat_d   = bus.keypad;
          count_d = CNT_ONE;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      HELD: begin
        if (bus.keypad == '0) begin
          count_d = CNT_ONE;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (bus.keypad == '0) begin
          count_d = count_inc;
          if (count_inc == CNT_MAX) begin
            count_d = '0;
            state_d = IDLE;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase

    // Disabled entry parks the FSM and discards any press outcome.
    if (!bus.enable) begin
      state_d = IDLE;
      count_d = '0;
      pat_d   = pat_q;
      ones_d  = ones_q;
      tens_d  = tens_q;
      min_d   = min_q;
      code_d  = code_q;
      valid_d = 1'b0;
      error_d = 1'b0;
    end

    // Clear wins over a same-edge accept; last key code is kept.
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      ones_d  = '0;
      tens_d  = '0;
      min_d   = '0;
      code_d  = code_q;
      valid_d = 1'b0;
      error_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pat_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      min_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pat_q   <= pat_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      min_q   <= min_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign bus.sec_ones  = ones_q;
  assign bus.sec_tens  = tens_q;
  assign bus.min       = min_q;
  assign bus.key_code  = code_q;
  assign bus.key_valid = valid_q;
  assign bus.key_error = error_q;

endmodule
